// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//   Sequencing controller for an unsigned multiply/accumulate stream. Each
//   operand pair is multiplied bit-serially (shift-add, one multiplier bit per
//   clock), and the product is added into a running accumulator. When the pair
//   marked "last" has been accumulated, the sum and a sticky carry-out flag are
//   presented on a valid/ready result port. The accumulator is then cleared
//   once the result has been taken.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous reset, active-high
//   clear      in   1     synchronous abort: drop current op, zero accumulator
//   in_valid   in   1     operand pair valid
//   in_ready   out  1     controller can accept a pair (registered)
//   in_a       in   AW    multiplicand, unsigned
//   in_b       in   BW    multiplier, unsigned
//   in_last    in   1     pair closes the current accumulation group
//   out_valid  out  1     out_acc / out_ovf valid (registered)
//   out_ready  in   1     sink accepts the result
//   out_acc    out  ACCW  accumulated sum of products, modulo 2^ACCW
//   out_ovf    out  1     sticky carry-out of the accumulator for this group
//   busy       out  1     controller not idle (registered)
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int AW   = 8,
  parameter int BW   = 8,
  parameter int ACCW = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_a,
  input  logic [BW-1:0]   in_b,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic            out_ovf,
  output logic            busy
);

  localparam int PW = AW + BW;                       // exact product width
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;     // multiplier bit index

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   a_sh_q;      // multiplicand, shifted left once per MUL cycle
  logic [BW-1:0]   b_sh_q;      // multiplier, shifted right once per MUL cycle
  logic            last_q;
  logic [PW-1:0]   prod_q;
  logic [CW-1:0]   cnt_q;
  logic [ACCW-1:0] acc_q;
  logic            ovf_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [PW-1:0]   prod_d;
  logic [ACCW:0]   sum_d;
  logic            cnt_last;

  // Unsigned accumulate with the carry-out returned in the MSB; the caller
  // keeps the low ACCW bits (modulo wrap) and ORs the carry into the flag.
  function automatic logic [ACCW:0] acc_add(input logic [ACCW-1:0] acc,
                                            input logic [PW-1:0]   prod);
    acc_add = {1'b0, acc} + {{(ACCW + 1 - PW){1'b0}}, prod};
  endfunction

  // Shift-add step: the current multiplier LSB selects whether the aligned
  // multiplicand is added. Partial sums never exceed PW bits.
  assign prod_d   = b_sh_q[0] ? (prod_q + a_sh_q) : prod_q;
  assign sum_d    = acc_add(acc_q, prod_q);
  assign cnt_last = (cnt_q == CW'(BW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= {{BW{1'b0}}, in_a};
            b_sh_q     <= in_b;
            last_q     <= in_last;
            prod_q     <= '0;
            cnt_q      <= '0;
            state_q    <= S_MUL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        // ---- multiply: one multiplier bit per edge, BW edges total ----
        S_MUL: begin
          prod_q <= prod_d;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_last) begin
            state_q <= S_ACC;
          end
        end

        // ---- accumulate: single edge, sticky carry ----
        S_ACC: begin
          acc_q <= sum_d[ACCW-1:0];
          ovf_q <= ovf_q | sum_d[ACCW];
          if (last_q) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        // ---- result: held until the sink takes it ----
        S_OUT: begin
          if (out_ready) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule
